// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control FSM and the MIPS datapath.
// master: the control FSM. slave: the datapath/IR/memory side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCWriteCondNe;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       ExtOp;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp,
               ALUSrcB, ALUOp, PCSource, state, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp,
               ALUSrcB, ALUOp, PCSource, state, illegal_op
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath. Sequences
// fetch/decode/execute/memory/write-back, stalls on mem_ready and traps
// unsupported opcodes back to FETCH with a one-cycle illegal_op pulse.
module multicycle_control #(
    parameter int EXT_OPS  = 1,
    parameter int MEM_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_IWB    = 4'd11,
        S_BNE    = 4'd12,
        S_LOGEX  = 4'd13
    } state_t;

    localparam logic EXT = (EXT_OPS != 0);

    state_t cur;
    state_t nxt;
    logic   ready;

    // Without wait support every memory access completes in one cycle.
    assign ready = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    // Next-state and Moore outputs (IRWrite/PCWrite in FETCH also follow ready).
    always_comb begin
        nxt               = S_FETCH;
        bus.PCWrite       = 1'b0;
        bus.PCWriteCond   = 1'b0;
        bus.PCWriteCondNe = 1'b0;
        bus.IorD          = 1'b0;
        bus.MemRead       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.RegDst        = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ALUSrcA       = 1'b0;
        bus.ExtOp         = 1'b1;
        bus.ALUSrcB       = 2'b00;
        bus.ALUOp         = 2'b00;
        bus.PCSource      = 2'b00;
        bus.illegal_op    = 1'b0;
        unique case (cur)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = ready;
                bus.PCWrite = ready;
                nxt         = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    6'b100011, 6'b101011: nxt = S_MEMADR;
                    6'b000000:            nxt = S_EXEC;
                    6'b000100:            nxt = S_BEQ;
                    6'b000010:            nxt = S_JUMP;
                    6'b001000:            nxt = S_ADDIEX;
                    6'b000101: begin
                        nxt            = EXT ? S_BNE : S_FETCH;
                        bus.illegal_op = ~EXT;
                    end
                    6'b001100, 6'b001101: begin
                        nxt            = EXT ? S_LOGEX : S_FETCH;
                        bus.illegal_op = ~EXT;
                    end
                    default: begin
                        nxt            = S_FETCH;
                        bus.illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                nxt         = bus.opcode[3] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                nxt         = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                nxt          = ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                nxt         = S_RWB;
            end
            S_RWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_BEQ: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
            S_BNE: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALUOp         = 2'b01;
                bus.PCWriteCondNe = 1'b1;
                bus.PCSource      = 2'b01;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            S_ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                nxt         = S_IWB;
            end
            S_LOGEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = 2'b11;
                bus.ExtOp   = 1'b0;
                nxt         = S_IWB;
            end
            S_IWB: begin
                bus.RegWrite = 1'b1;
            end
            // Unused encodings recover to FETCH.
            default: nxt = S_FETCH;
        endcase
    end

    assign bus.state = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: dut1 (EXT_OPS=1, MEM_WAIT=1) and
// dut0 (EXT_OPS=0, MEM_WAIT=0) share clock, reset and inputs.
module tb_multicycle_control;
    typedef struct packed {
        logic pcw, pcwc, pcwcne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ext;
        logic [1:0] srcb, aluop, pcsrc;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        int         n;
        int         p[5];
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op  = 6'd0;
    logic       rdy = 1'b1;
    int         total = 0;
    int         bad   = 0;
    bit         chk_en = 1'b0;

    multicycle_control_if i1 ();
    multicycle_control_if i0 ();

    multicycle_control #(.EXT_OPS(1), .MEM_WAIT(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.master));
    multicycle_control #(.EXT_OPS(0), .MEM_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(i0.master));

    assign i1.opcode = op;
    assign i1.mem_ready = rdy;
    assign i0.opcode = op;
    assign i0.mem_ready = rdy;

    always #5 clk = ~clk;

    ctl_t       ctl_g[2];
    logic [3:0] st_g[2];
    logic       ill_g[2];
    assign ctl_g[1] = {i1.PCWrite, i1.PCWriteCond, i1.PCWriteCondNe, i1.IorD, i1.MemRead,
                       i1.MemWrite, i1.IRWrite, i1.MemtoReg, i1.RegDst, i1.RegWrite,
                       i1.ALUSrcA, i1.ExtOp, i1.ALUSrcB, i1.ALUOp, i1.PCSource};
    assign ctl_g[0] = {i0.PCWrite, i0.PCWriteCond, i0.PCWriteCondNe, i0.IorD, i0.MemRead,
                       i0.MemWrite, i0.IRWrite, i0.MemtoReg, i0.RegDst, i0.RegWrite,
                       i0.ALUSrcA, i0.ExtOp, i0.ALUSrcB, i0.ALUOp, i0.PCSource};
    assign st_g[1]  = i1.state;
    assign st_g[0]  = i0.state;
    assign ill_g[1] = i1.illegal_op;
    assign ill_g[0] = i0.illegal_op;

    // Control word each state asserts; r is the effective memory-ready.
    function automatic ctl_t spec_ctl(input int s, input bit r);
        ctl_t c;
        c = '0;
        c.ext = 1'b1;
        case (s)
            0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = r; c.pcw = r; end
            1:  c.srcb = 2'b11;
            2:  begin c.srca = 1; c.srcb = 2'b10; end
            3:  begin c.iord = 1; c.mrd = 1; end
            4:  begin c.rw = 1; c.m2r = 1; end
            5:  begin c.iord = 1; c.mwr = 1; end
            6:  begin c.srca = 1; c.aluop = 2'b10; end
            7:  begin c.rdst = 1; c.rw = 1; end
            8:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
            9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
            10: begin c.srca = 1; c.srcb = 2'b10; end
            11: c.rw = 1;
            12: begin c.srca = 1; c.aluop = 2'b01; c.pcwcne = 1; c.pcsrc = 2'b01; end
            13: begin c.srca = 1; c.srcb = 2'b10; c.aluop = 2'b11; c.ext = 0; end
            default: ;
        endcase
        return c;
    endfunction

    // Zero-wait state path of one instruction; length 2 means trapped.
    function automatic void ref_path(input logic [5:0] o, input bit ext, output int n, output int p[5]);
        p = '{0, 1, 0, 0, 0};
        n = 2;
        case (o)
            6'b100011: begin p = '{0, 1, 2, 3, 4};  n = 5; end
            6'b101011: begin p = '{0, 1, 2, 5, 0};  n = 4; end
            6'b000000: begin p = '{0, 1, 6, 7, 0};  n = 4; end
            6'b000100: begin p = '{0, 1, 8, 0, 0};  n = 3; end
            6'b000010: begin p = '{0, 1, 9, 0, 0};  n = 3; end
            6'b001000: begin p = '{0, 1, 10, 11, 0}; n = 4; end
            6'b000101: if (ext) begin p = '{0, 1, 12, 0, 0}; n = 3; end
            6'b001100, 6'b001101: if (ext) begin p = '{0, 1, 13, 11, 0}; n = 4; end
            default: ;
        endcase
    endfunction

    function automatic bit is_illegal(input logic [5:0] o, input bit ext);
        int n;
        int p[5];
        ref_path(o, ext, n, p);
        return n == 2;
    endfunction

    // Reference model: position within the current instruction's path.
    int m_i[2]    = '{0, 0};
    int m_n[2]    = '{2, 2};
    int m_st[2]   = '{0, 0};
    int m_path[2][5];

    always @(posedge clk) begin
        bit r;
        int n;
        int p[5];
        for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? 1'b1 : rdy;
            if (rst) begin
                m_i[k] = 0;
            end else if (m_i[k] == 0) begin
                if (r) m_i[k] = 1;
            end else if (m_i[k] == 1) begin
                ref_path(op, k == 1, n, p);
                m_path[k] = p;
                m_n[k]    = n;
                m_i[k]    = (n > 2) ? 2 : 0;
            end else if (!((m_st[k] == 3 || m_st[k] == 5) && !r)) begin
                m_i[k] = (m_i[k] + 1 < m_n[k]) ? m_i[k] + 1 : 0;
            end
            m_st[k] = (m_i[k] < 2) ? m_i[k] : m_path[k][m_i[k]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Random-phase comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rnd_state%0d", k), 32'(st_g[k]), 32'(m_st[k]));
                chk($sformatf("rnd_ctl%0d", k), 32'(ctl_g[k]), 32'(spec_ctl(m_st[k], (k == 0) ? 1'b1 : rdy)));
                chk($sformatf("rnd_ill%0d", k), 32'(ill_g[k]), 32'((m_st[k] == 1) && is_illegal(op, k == 1)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input int s, input bit ill);
        chk({nm, "_state"}, 32'(i1.state), 32'(s));
        chk({nm, "_ctl"}, 32'(ctl_g[1]), 32'(spec_ctl(s, rdy)));
        chk({nm, "_ill"}, 32'(i1.illegal_op), 32'(ill));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        step();
        chk1("reset", 0, 1'b0);
        chk("reset_state0", 32'(i0.state), 32'd0);
        rst = 1'b0;
    endtask

    logic [5:0] ops[9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                           6'b001000, 6'b000101, 6'b001100, 6'b001101};

    initial begin
        vec_t tbl[11];
        int   lw_st[8];
        bit   lw_rd[8];

        tbl[0]  = '{6'b000000, 4, '{0, 1, 6, 7, 0}};
        tbl[1]  = '{6'b100011, 5, '{0, 1, 2, 3, 4}};
        tbl[2]  = '{6'b101011, 4, '{0, 1, 2, 5, 0}};
        tbl[3]  = '{6'b000100, 3, '{0, 1, 8, 0, 0}};
        tbl[4]  = '{6'b000010, 3, '{0, 1, 9, 0, 0}};
        tbl[5]  = '{6'b001000, 4, '{0, 1, 10, 11, 0}};
        tbl[6]  = '{6'b000101, 3, '{0, 1, 12, 0, 0}};
        tbl[7]  = '{6'b001100, 4, '{0, 1, 13, 11, 0}};
        tbl[8]  = '{6'b001101, 4, '{0, 1, 13, 11, 0}};
        tbl[9]  = '{6'b111111, 2, '{0, 1, 0, 0, 0}};
        tbl[10] = '{6'b010000, 2, '{0, 1, 0, 0, 0}};

        // Table: zero-wait instruction paths on the extended-ops instance.
        for (int t = 0; t < 11; t++) begin
            do_reset();
            op = tbl[t].op;
            for (int c = 0; c < tbl[t].n; c++) begin
                chk1($sformatf("tbl%0d_c%0d", t, c), tbl[t].p[c], (tbl[t].n == 2) && (c == 1));
                step();
            end
            chk($sformatf("tbl%0d_ret", t), 32'(i1.state), 32'd0);
        end

        // lw with two wait cycles in MEMRD: 7 cycles total.
        lw_st = '{0, 1, 2, 3, 3, 3, 4, 0};
        lw_rd = '{1, 1, 1, 0, 0, 1, 1, 1};
        do_reset();
        op = 6'b100011;
        for (int c = 0; c < 8; c++) begin
            rdy = lw_rd[c];
            chk1($sformatf("lwwait_c%0d", c), lw_st[c], 1'b0);
            step();
        end

        // FETCH stall holds with IRWrite/PCWrite low.
        do_reset();
        op  = 6'b000000;
        rdy = 1'b0;
        step();
        chk1("fetch_hold", 0, 1'b0);
        chk("fetch_nowait_dut0", 32'(i0.state), 32'd1);
        rdy = 1'b1;
        step();
        chk1("fetch_go", 1, 1'b0);

        // Reset while MEMWR is stalled: access abandoned.
        do_reset();
        op = 6'b101011;
        step(); step(); step();
        rdy = 1'b0;
        chk1("memwr_in", 5, 1'b0);
        step();
        chk1("memwr_hold", 5, 1'b0);
        rst = 1'b1;
        step();
        chk1("memwr_rst", 0, 1'b0);
        chk("memwr_rst_mw", 32'(i1.MemWrite), 32'd0);
        rst = 1'b0;
        rdy = 1'b1;

        // bne trapped without extended ops; 111111 trapped on both.
        do_reset();
        op = 6'b000101;
        step();
        chk("bne0_dec", 32'(i0.state), 32'd1);
        chk("bne0_ill", 32'(i0.illegal_op), 32'd1);
        chk("bne1_ill", 32'(i1.illegal_op), 32'd0);
        step();
        chk("bne0_ret", 32'(i0.state), 32'd0);
        chk("bne0_ill_off", 32'(i0.illegal_op), 32'd0);
        chk1("bne1_exec", 12, 1'b0);
        do_reset();
        op = 6'b111111;
        step();
        chk("ff_ill0", 32'(i0.illegal_op), 32'd1);
        chk("ff_ill1", 32'(i1.illegal_op), 32'd1);
        step();
        chk("ff_ret0", 32'(i0.state), 32'd0);
        chk("ff_ret1", 32'(i1.state), 32'd0);

        // Random phase against the model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            if (m_st[0] == 0 && m_st[1] == 0)
                op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            step();
        end
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
